// File: rtl/mem_ctrl_if.sv
// Request, response and RAM-port signals of the byte-serial memory controller.
// The slave side is the controller; the master side is the pipeline plus RAM wrapper.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic [7:0]  if_byte;
    logic        if_byte_valid;
    logic        if_done;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_len;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        busy;

    modport master (
        output if_req, if_addr, flush, ls_req, ls_we, ls_len, ls_addr, ls_wdata, mem_din,
        input  if_byte, if_byte_valid, if_done, ls_rdata, ls_done, mem_a, mem_dout, mem_wr, busy
    );

    modport slave (
        input  if_req, if_addr, flush, ls_req, ls_we, ls_len, ls_addr, ls_wdata, mem_din,
        output if_byte, if_byte_valid, if_done, ls_rdata, ls_done, mem_a, mem_dout, mem_wr, busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves instruction fetch and load/store requests
// over a single 8-bit RAM port, one byte per cycle, little-endian.
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_issue, r_recv, r_n;
    logic [2:0]  w_issue_nxt, w_recv_nxt, w_n_nxt, w_len_n;
    logic [31:0] r_base, r_wdata, r_rdata;
    logic [31:0] w_base_nxt, w_wdata_nxt, w_rdata_nxt;
    logic        w_idle, w_rd_act, w_issue_go, w_capture, w_last_rd;
    logic        w_store, w_last_wr, w_done, w_acc_ls, w_acc_if;

    assign w_idle     = (r_state == IDLE);
    assign w_rd_act   = (r_state == LOAD) || ((r_state == FETCH) && !bus.flush);
    assign w_issue_go = w_rd_act && (r_issue < r_n);
    assign w_capture  = w_rd_act && (r_recv < r_issue);
    assign w_last_rd  = w_capture && ((r_recv + 3'd1) == r_n);
    assign w_store    = (r_state == STORE);
    assign w_last_wr  = w_store && ((r_issue + 3'd1) == r_n);
    assign w_done     = w_last_rd || w_last_wr;
    // On the completing cycle only the other requester may be accepted, since the
    // finishing requester still holds its req high in that cycle.
    assign w_acc_ls   = bus.ls_req && (w_idle || (w_done && (r_state == FETCH)));
    assign w_acc_if   = bus.if_req && !bus.flush &&
                        ((w_idle && !bus.ls_req) || (w_done && (r_state != FETCH)));

    always_comb begin
        case (bus.ls_len)
            2'b00:   w_len_n = 3'd1;
            2'b01:   w_len_n = 3'd2;
            default: w_len_n = 3'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_issue <= '0;
            r_recv  <= '0;
            r_n     <= '0;
            r_base  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            r_issue <= w_issue_nxt;
            r_recv  <= w_recv_nxt;
            r_n     <= w_n_nxt;
            r_base  <= w_base_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_nxt = r_issue;
        w_recv_nxt  = r_recv;
        w_n_nxt     = r_n;
        w_base_nxt  = r_base;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        if (w_issue_go || w_store)
            w_issue_nxt = r_issue + 3'd1;
        if (w_capture) begin
            w_recv_nxt = r_recv + 3'd1;
            if (r_state == LOAD)
                w_rdata_nxt[{r_recv[1:0], 3'b000} +: 8] = bus.mem_din;
        end
        if (w_done || ((r_state == FETCH) && bus.flush))
            w_state_nxt = IDLE;
        if (w_acc_ls) begin
            w_state_nxt = bus.ls_we ? STORE : LOAD;
            w_base_nxt  = bus.ls_addr;
            w_n_nxt     = w_len_n;
            w_wdata_nxt = bus.ls_wdata;
            w_rdata_nxt = '0;
            w_issue_nxt = '0;
            w_recv_nxt  = '0;
        end else if (w_acc_if) begin
            w_state_nxt = FETCH;
            w_base_nxt  = bus.if_addr;
            w_n_nxt     = 3'd4;
            w_issue_nxt = '0;
            w_recv_nxt  = '0;
        end
    end

    always_comb begin
        bus.mem_a         = '0;
        bus.mem_dout      = '0;
        bus.mem_wr        = 1'b0;
        bus.if_byte       = '0;
        bus.if_byte_valid = 1'b0;
        bus.if_done       = 1'b0;
        bus.ls_rdata      = r_rdata;
        bus.ls_done       = ((r_state == LOAD) && w_last_rd) || w_last_wr;
        bus.busy          = !w_idle;
        if (w_issue_go || w_store)
            bus.mem_a = r_base + {29'd0, r_issue};
        if (w_store) begin
            bus.mem_dout = r_wdata[{r_issue[1:0], 3'b000} +: 8];
            bus.mem_wr   = 1'b1;
        end
        if (w_capture) begin
            if (r_state == FETCH) begin
                bus.if_byte       = bus.mem_din;
                bus.if_byte_valid = 1'b1;
                bus.if_done       = w_last_rd;
            end else begin
                bus.ls_rdata[{r_recv[1:0], 3'b000} +: 8] = bus.mem_din;
            end
        end
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller that answers the instruction-fetch stage and the load/store stage over the single 8-bit RAM port. It accepts a 32-bit fetch or load/store request, walks the RAM one byte per cycle, and streams fetched bytes back to the fetch stage lowest byte first, so the fetch stage can assemble the 32-bit instruction. It sits between the pipeline front/back ends and the RAM wrapper, and it is the only block that drives the RAM address bus.

## Interface
- No parameters.
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low freezes all state and outputs, with no progress
- if_req  in  1  fetch request, held high until `if_done`
- if_addr  in  32  fetch address, sampled at acceptance
- flush  in  1  jump taken: abort any fetch in progress
- if_byte  out  8  fetched byte (byte k = bits 8k+7:8k of the instruction)
- if_byte_valid  out  1  `if_byte` is valid this cycle
- if_done  out  1  one-cycle pulse with the 4th fetched byte
- ls_req  in  1  load/store request, held until `ls_done`
- ls_we  in  1  1 = store, 0 = load
- ls_len  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- ls_addr  in  32  load/store base address
- ls_wdata  in  32  store data; the low `len` bytes are used
- ls_rdata  out  32  load data, zero-extended, little-endian
- ls_done  out  1  one-cycle completion pulse
- mem_a  out  32  RAM address
- mem_dout  out  8  RAM write byte
- mem_wr  out  1  RAM write enable
- mem_din  in  8  RAM read byte, valid one cycle after its address
- busy  out  1  controller not in IDLE

## Operation
- States: IDLE, FETCH, LOAD, STORE. Counters: `issue` (0–4) and `recv` (0–4), plus `n` = byte count (1, 2 or 4).
- In IDLE, `ls_req` has priority over `if_req`.
  - Acceptance latches the address, `n`, and the write data, clears both counters, and enters LOAD, STORE or FETCH. FETCH always uses `n` = 4.
- In FETCH and LOAD, each cycle while `issue` < `n`:
  - `mem_a` = base + `issue`, computed mod 2^32 (the address wraps).
  - `issue` increments.
- In FETCH and LOAD, each cycle after an issue cycle, `mem_din` is captured as byte `recv`.
  - FETCH: `if_byte` = `mem_din` and `if_byte_valid` = 1.
  - LOAD: the byte is written into `ls_rdata[8*recv+7:8*recv]`; `ls_rdata` is cleared to 0 at acceptance.
- When `recv` reaches `n`, the block pulses `if_done` (FETCH) or `ls_done` (LOAD) together with the last byte and returns to IDLE.
- STORE: each cycle, `mem_a` = base + k, `mem_dout` = `ls_wdata[8k+7:8k]` and `mem_wr` = 1, for k = 0..`n`-1.
  - `ls_done` pulses in the same cycle as the last write; the next state is IDLE.
- `flush`:
  - In FETCH, the fetch is abandoned immediately. In that cycle: no `if_byte_valid`, no `if_done`, `mem_wr` = 0. The next state is IDLE. A RAM read still in flight is discarded.
  - In IDLE, a same-cycle `if_req` is not accepted; `ls_req` is still accepted.
  - In LOAD or STORE, `flush` is ignored; the data access always completes.
- When no write is occurring, `mem_wr` = 0 and `mem_dout` = 0. In IDLE, `mem_a` = 0.
- Reset values: `if_byte` = 0, `if_byte_valid` = 0, `if_done` = 0, `ls_rdata` = 0, `ls_done` = 0, `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0, `busy` = 0. State = IDLE, counters = 0.
- Reset mid-operation drops the transaction; no done pulse is produced.

## Timing
- The request is sampled at edge 0. The first `mem_a` is driven in the cycle after that edge.
- Word fetch or load:
  - Addresses are driven in cycles 1–4.
  - Bytes are captured in cycles 2–5.
  - The done pulse occurs in cycle 5.
  - `busy` is high in cycles 1–5.
  - A new request can be accepted at the edge that ends cycle 5, so back-to-back word reads take 5 cycles each.
- Byte load: done in cycle 2. Half-word load: done in cycle 3.
- Store of `n` bytes: writes occur in cycles 1..`n`, with done in cycle `n`.
- Requesters must hold `req` and inputs stable until done. The controller does not re-sample the address or data mid-transaction.
- If `rdy` goes low mid-transaction, state, counters and all outputs hold. The RAM wrapper is also frozen by `rdy`, so a captured byte is not lost.

## Test plan
- **Word fetch:** RAM[0x100..0x103] = 13,05,A0,00; pulse `if_req` with `if_addr` = 0x100.
  - `if_byte` carries 13, 05, A0, 00 in cycles 2–5 with `if_byte_valid` high.
  - `if_done` is high only in cycle 5.
  - `mem_wr` stays 0 throughout.
- **Simultaneous requests:** `if_req` and `ls_req` (load word at 0x200 = 0xDEADBEEF) in the same cycle.
  - The load is served first: `ls_rdata` = 0xDEADBEEF and `ls_done` in cycle 5.
  - The fetch is accepted next; its first address appears in cycle 6.
- **Half-word store:** `ls_addr` = 0x3FF, `ls_wdata` = 0x12345678.
  - Cycle 1: `mem_a` = 0x3FF, `mem_dout` = 78, `mem_wr` = 1.
  - Cycle 2: `mem_a` = 0x400, `mem_dout` = 56, `mem_wr` = 1; `ls_done` in cycle 2.
  - A following byte load from 0x400 returns 0x00000056.
- **Flush mid-fetch:** assert `flush` in cycle 3 of a word fetch.
  - No `if_done`; `if_byte_valid` = 0 from cycle 3 on.
  - `busy` = 0 in cycle 4.
  - A new fetch at 0x80 completes normally.
- **Address wrap, rdy stall, and reset:**
  - Word fetch at 0xFFFFFFFE: `mem_a` = FFFFFFFE, FFFFFFFF, 0, 1.
  - `rdy` = 0 for 3 cycles mid-load: done is delayed by exactly 3 cycles with identical data.
  - `rst` mid-store: all outputs are 0 next cycle, with no `ls_done`.
